// File: rtl/s9234_n1146_bist_driver_if.sv
// Control, pattern and signature bundle between the s9234 n1146 BIST driver and its wrapper.
// The slave side is the BIST driver; the master side is the wrapper/controller.
interface s9234_n1146_bist_driver_if;
  logic        start;
  logic        seed_load;
  logic [17:0] seed_in;
  logic [17:0] pat_out;
  logic        resp_in;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] pattern_count;

  modport master (
    output start, seed_load, seed_in, resp_in,
    input  pat_out, busy, done, signature, pattern_count
  );

  modport slave (
    input  start, seed_load, seed_in, resp_in,
    output pat_out, busy, done, signature, pattern_count
  );
endinterface

// File: rtl/s9234_n1146_bist_driver.sv
// LFSR pattern source and serial 16-bit MISR compactor for the n1146 cone of s9234.
// Responses arrive RESP_LAT cycles after their vector and are tagged by a valid delay line.
module s9234_n1146_bist_driver #(
  parameter int          NUM_PATTERNS = 256,
  parameter int          RESP_LAT     = 0,
  parameter logic [17:0] DEFAULT_SEED = 18'h00001
) (
  input logic                       clock,
  input logic                       reset,
  s9234_n1146_bist_driver_if.slave  bus
);

  if (NUM_PATTERNS < 1 || NUM_PATTERNS > 65535) begin : g_bad_num_patterns
    $error("NUM_PATTERNS must be in 1..65535");
  end
  if (RESP_LAT < 0 || RESP_LAT > 2) begin : g_bad_resp_lat
    $error("RESP_LAT must be 0, 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int          VW   = (RESP_LAT == 0) ? 1 : RESP_LAT;
  localparam logic [15:0] LAST = 16'(NUM_PATTERNS);

  state_t      state_q, state_d;
  logic [17:0] lfsr_q, lfsr_d;
  logic [15:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic [VW-1:0] vld_q, vld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        in_run;
  logic        resp_valid;
  logic        fb;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    sig_d      = sig_q;
    cnt_d      = cnt_q;
    in_run     = (state_q == RUN);
    vld_d      = '0;
    vld_d[0]   = in_run;
    for (int i = 1; i < VW; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    resp_valid = (RESP_LAT == 0) ? in_run : vld_q[VW-1];
    fb         = sig_q[15] ^ bus.resp_in;

    if (resp_valid) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end

    // seed_load wins over start; the run must be requested again afterwards
    case (state_q)
      IDLE, DONE: begin
        if (bus.seed_load) begin
          lfsr_d = (bus.seed_in == '0) ? 18'h00001 : bus.seed_in;
        end else if (bus.start) begin
          state_d = RUN;
          sig_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d  = cnt_q + 16'd1;
        lfsr_d = {lfsr_q[16:0], lfsr_q[17] ^ lfsr_q[10]};
        if (cnt_d == LAST) begin
          state_d = (RESP_LAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (vld_d == '0) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= DEFAULT_SEED;
      sig_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.pat_out       = lfsr_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.signature     = sig_q;
  assign bus.pattern_count = cnt_q;

endmodule

// File: tb/tb_s9234_n1146_bist_driver.sv
// Scoreboard bench for the n1146 BIST driver: three instances cover 12/0, 4/0 and 256/2
// (NUM_PATTERNS/RESP_LAT); end-of-run results are checked by per-instance monitors.
module tb_s9234_n1146_bist_driver;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  s9234_n1146_bist_driver_if if12();
  s9234_n1146_bist_driver_if if4();
  s9234_n1146_bist_driver_if if256();

  s9234_n1146_bist_driver #(.NUM_PATTERNS(12), .RESP_LAT(0)) u12 (
    .clock(clock), .reset(reset), .bus(if12));
  s9234_n1146_bist_driver #(.NUM_PATTERNS(4), .RESP_LAT(0)) u4 (
    .clock(clock), .reset(reset), .bus(if4));
  s9234_n1146_bist_driver #(.NUM_PATTERNS(256), .RESP_LAT(2)) u256 (
    .clock(clock), .reset(reset), .bus(if256));

  typedef struct {
    logic [15:0] sig;
    logic [15:0] cnt;
  } exp_t;

  exp_t q12[$];
  exp_t q4[$];
  exp_t q256[$];
  exp_t e12, e4, e256;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Stand-in golden model of the n1146 cone
  function automatic logic cone(logic [17:0] v);
    return ((v[0] & v[5]) | (v[3] ^ v[11])) ^ ((v[17] & ~v[8]) | (v[2] & v[14] & v[9])) ^ v[13];
  endfunction

  function automatic logic [17:0] lfsr_next(logic [17:0] v);
    logic [17:0] n;
    n = (v << 1) & 18'h3FFFF;
    if (v[17] != v[10]) n = n | 18'h00001;
    return n;
  endfunction

  function automatic logic [15:0] misr_step(logic [15:0] s, logic r);
    logic [15:0] t;
    t = s << 1;
    return (s[15] != r) ? (t ^ 16'h1021) : t;
  endfunction

  task automatic model_run(input logic [17:0] seed, input int n,
                           output logic [15:0] sig, output logic [17:0] v_end);
    logic [17:0] v;
    v   = (seed == 18'h0) ? 18'h00001 : seed;
    sig = 16'h0;
    for (int k = 0; k < n; k++) begin
      sig = misr_step(sig, cone(v));
      v   = lfsr_next(v);
    end
    v_end = v;
  endtask

  // Two-stage registered cone feeding the RESP_LAT=2 instance
  logic d1 = 1'b0, d2 = 1'b0;
  always @(posedge clock) begin
    d1 <= cone(if256.pat_out);
    d2 <= d1;
  end
  assign if256.resp_in = d2;
  assign if12.resp_in  = 1'b0;

  logic done12_prev = 1'b0, done4_prev = 1'b0, done256_prev = 1'b0;

  always @(negedge clock) begin
    if (if12.done && !done12_prev) begin
      if (q12.size() == 0) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL sb12_unexpected_done: got done, expected no run result");
      end else begin
        e12 = q12.pop_front();
        checkOutput("sb12_signature", 32'(if12.signature), 32'(e12.sig));
        checkOutput("sb12_count", 32'(if12.pattern_count), 32'(e12.cnt));
      end
    end
    done12_prev <= if12.done;
  end

  always @(negedge clock) begin
    if (if4.done && !done4_prev) begin
      if (q4.size() == 0) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL sb4_unexpected_done: got done, expected no run result");
      end else begin
        e4 = q4.pop_front();
        checkOutput("sb4_signature", 32'(if4.signature), 32'(e4.sig));
        checkOutput("sb4_count", 32'(if4.pattern_count), 32'(e4.cnt));
      end
    end
    done4_prev <= if4.done;
  end

  always @(negedge clock) begin
    if (if256.done && !done256_prev) begin
      if (q256.size() == 0) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL sb256_unexpected_done: got done, expected no run result");
      end else begin
        e256 = q256.pop_front();
        checkOutput("sb256_signature", 32'(if256.signature), 32'(e256.sig));
        checkOutput("sb256_count", 32'(if256.pattern_count), 32'(e256.cnt));
      end
    end
    done256_prev <= if256.done;
  end

  // One 4-vector run with responses forced from a bit mask (bit k = vector k+1)
  task automatic applyStimulus(input logic [3:0] mask);
    exp_t e;
    e.sig = 16'h0;
    for (int k = 0; k < 4; k++) e.sig = misr_step(e.sig, mask[k]);
    e.cnt = 16'd4;
    q4.push_back(e);
    @(posedge clock); #1 if4.start = 1'b1;
    @(posedge clock); #1 if4.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if4.resp_in = mask[k];
      @(posedge clock); #1;
    end
    if4.resp_in = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic waitDone12(input int budget);
    int c;
    c = 0;
    while (!if12.done && c < budget) begin
      @(negedge clock);
      c++;
    end
    checkOutput("dut12_done_in_budget", 32'(if12.done), 32'd1);
  endtask

  // Full 256-vector run; start in RUN and seed_load in RUN/DRAIN must have no effect
  task automatic run256(input logic [17:0] seed, input logic disturb);
    exp_t e;
    logic [17:0] v_end;
    int busy_cnt;
    model_run(seed, 256, e.sig, v_end);
    e.cnt = 16'd256;
    q256.push_back(e);
    @(posedge clock); #1 if256.seed_load = 1'b1; if256.seed_in = seed;
    @(posedge clock); #1 if256.seed_load = 1'b0; if256.start = 1'b1;
    @(posedge clock); #1 if256.start = 1'b0;
    busy_cnt = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clock);
      if (!if256.busy) break;
      busy_cnt++;
      if (disturb) begin
        if256.start     = (c == 50) || (c == 257);
        if256.seed_load = (c == 100) || (c == 257);
        if256.seed_in   = 18'($urandom);
      end
    end
    if256.start = 1'b0;
    if256.seed_load = 1'b0;
    checkOutput("dut256_busy_cycles", 32'(busy_cnt), 32'd258);
    checkOutput("dut256_done", 32'(if256.done), 32'd1);
    checkOutput("dut256_lfsr_after_run", 32'(if256.pat_out), 32'(v_end));
    @(posedge clock); #1;
  endtask

  logic [17:0] v;
  logic [17:0] rseed;
  exp_t e;

  initial begin
    reset = 1'b1;
    if12.start = 0; if12.seed_load = 0; if12.seed_in = 0;
    if4.start = 0; if4.seed_load = 0; if4.seed_in = 0; if4.resp_in = 0;
    if256.start = 0; if256.seed_load = 0; if256.seed_in = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_pat_out", 32'(if12.pat_out), 32'h00001);
    checkOutput("reset_signature", 32'(if12.signature), 32'h0);
    checkOutput("reset_busy", 32'(if12.busy), 32'h0);
    checkOutput("reset_done", 32'(if12.done), 32'h0);
    checkOutput("reset_count", 32'(if256.pattern_count), 32'h0);

    // LFSR sequence from seed 1 over a 12-vector run
    e.sig = 16'h0; e.cnt = 16'd12;
    q12.push_back(e);
    @(posedge clock); #1 if12.seed_load = 1'b1; if12.seed_in = 18'h00001;
    @(posedge clock); #1 if12.seed_load = 1'b0; if12.start = 1'b1;
    @(posedge clock); #1 if12.start = 1'b0;
    v = 18'h00001;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      checkOutput($sformatf("lfsr_pat_cycle%0d", k), 32'(if12.pat_out), 32'(v));
      checkOutput($sformatf("lfsr_busy_cycle%0d", k), 32'(if12.busy), 32'd1);
      if (k == 12) checkOutput("lfsr_pat_cycle12_literal", 32'(if12.pat_out), 32'h00801);
      v = lfsr_next(v);
    end
    @(negedge clock);
    checkOutput("lfsr_done_after_12", 32'(if12.done), 32'd1);
    checkOutput("lfsr_count_12", 32'(if12.pattern_count), 32'd12);
    @(negedge clock);
    checkOutput("lfsr_holds_in_done", 32'(if12.pat_out), 32'(v));

    // Zero seed substitution, then simultaneous seed_load+start
    @(posedge clock); #1 if12.seed_load = 1'b1; if12.seed_in = 18'h00000;
    @(posedge clock); #1 if12.seed_load = 1'b0;
    @(negedge clock);
    checkOutput("zero_seed_pat_out", 32'(if12.pat_out), 32'h00001);
    e.sig = 16'h0; e.cnt = 16'd12;
    q12.push_back(e);
    @(posedge clock); #1 if12.seed_load = 1'b1; if12.seed_in = 18'h00003; if12.start = 1'b1;
    @(posedge clock); #1 if12.seed_load = 1'b0;
    @(negedge clock);
    checkOutput("seed_start_not_busy", 32'(if12.busy), 32'd0);
    checkOutput("seed_start_seed_loaded", 32'(if12.pat_out), 32'h00003);
    @(posedge clock); #1 if12.start = 1'b0;
    @(negedge clock);
    checkOutput("seed_start_run_vector1", 32'(if12.pat_out), 32'h00003);
    waitDone12(40);

    // Tied-response compaction on the 4-vector instance
    applyStimulus(4'b0000);
    checkOutput("tied_zero_signature", 32'(if4.signature), 32'h0000);
    applyStimulus(4'b1000);
    checkOutput("fourth_only_signature", 32'(if4.signature), 32'h1021);
    applyStimulus(4'b0100);
    checkOutput("third_only_signature", 32'(if4.signature), 32'h2042);
    for (int i = 0; i < 6; i++) applyStimulus(4'($urandom));

    // Latency-2 run from seed 1, with ignored start/seed_load pulses
    run256(18'h00001, 1'b1);

    // Reset part-way through a run
    @(posedge clock); #1 if256.seed_load = 1'b1; if256.seed_in = 18'h2A5C3;
    @(posedge clock); #1 if256.seed_load = 1'b0; if256.start = 1'b1;
    @(posedge clock); #1 if256.start = 1'b0;
    repeat (100) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("midreset_busy", 32'(if256.busy), 32'd0);
    checkOutput("midreset_done", 32'(if256.done), 32'd0);
    checkOutput("midreset_signature", 32'(if256.signature), 32'h0);
    checkOutput("midreset_count", 32'(if256.pattern_count), 32'h0);
    checkOutput("midreset_pat_out", 32'(if256.pat_out), 32'h00001);
    run256(18'h00001, 1'b0);

    for (int i = 0; i < 3; i++) begin
      rseed = 18'($urandom);
      run256(rseed, (i == 1));
    end

    repeat (4) @(posedge clock);
    @(negedge clock);
    checkOutput("sb12_drained", 32'(q12.size()), 32'd0);
    checkOutput("sb4_drained", 32'(q4.size()), 32'd0);
    checkOutput("sb256_drained", 32'(q256.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
